// File: rtl/ddr3_read_checker_pkg.sv
// Shared definitions for the DDR3 read checker: widths, FSM encoding, beat payload
// and the write/read data pattern so writer and checker cannot diverge.
package ddr3_read_checker_pkg;

    localparam int unsigned ADDR_W = 26;
    localparam int unsigned BC_W   = 5;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned BEAT_W = 10;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } chk_state_t;

    // One registered beat awaiting comparison
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] expd;
        logic [BEAT_W-1:0] idx;
        logic              last;
    } beat_t;

    // Expected beat: low word is base + index (mod 2^32), high word its complement
    function automatic logic [DATA_W-1:0] pattern_exp(input logic [ADDR_W-1:0] base,
                                                      input logic [BEAT_W-1:0] idx);
        logic [WORD_W-1:0] w;
        w = WORD_W'(base) + WORD_W'(idx);
        return {~w, w};
    endfunction

    // Beats in a check; a burst count of 0 means 32 bursts
    function automatic logic [BEAT_W-1:0] total_beats(input logic [BC_W-1:0] bc,
                                                      input int unsigned    bpb);
        logic [BEAT_W-1:0] bursts;
        bursts = (bc == '0) ? BEAT_W'(32) : BEAT_W'(bc);
        return BEAT_W'(bursts * BEAT_W'(bpb));
    endfunction

endpackage

// File: rtl/ddr3_pattern_gen.sv
// Combinational expected-data generator, shared by the write exerciser and the read checker.
module ddr3_pattern_gen
    import ddr3_read_checker_pkg::*;
(
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [BEAT_W-1:0] beat_idx,
    output logic [DATA_W-1:0] exp_data_c
);

    assign exp_data_c = pattern_exp(base_addr, beat_idx);

endmodule

// File: rtl/ddr3_read_checker.sv
// Checks DDR3 local read beats against the exerciser pattern and reports
// pass/fail, a saturating error count, first-failure capture, timeout and overrun.
module ddr3_read_checker
    import ddr3_read_checker_pkg::*;
#(
    parameter int unsigned BEATS_PER_BURST = 2,
    parameter int unsigned ERR_W           = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [BC_W-1:0]   burst_cnt,
    input  logic [DATA_W-1:0] read_data,
    input  logic              read_data_valid,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic              overrun,
    output logic [ERR_W-1:0]  err_count,
    output logic [BEAT_W-1:0] first_err_beat,
    output logic [DATA_W-1:0] first_err_data,
    output logic [DATA_W-1:0] first_err_exp
);

    localparam int unsigned      TMO_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    chk_state_t        state;
    chk_state_t        state_next;
    logic [ADDR_W-1:0] base_q;
    logic [BEAT_W-1:0] total_q;
    logic [BEAT_W-1:0] beat_idx;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              ovr_pend;
    logic              beat_v;
    beat_t             beat_q;
    logic [DATA_W-1:0] exp_c;
    logic              active_c;
    logic              accept_c;
    logic              tmo_hit_c;
    logic              tmo_fire_c;
    logic              last_done_c;
    logic              mism_c;
    logic              clean_c;

    ddr3_pattern_gen u_pattern_gen (
        .base_addr  (base_q),
        .beat_idx   (beat_idx),
        .exp_data_c (exp_c)
    );

    assign active_c    = (state == ST_ARMED) || (state == ST_CHECK);
    assign accept_c    = read_data_valid && active_c && (beat_idx < total_q);
    // Threshold is hit on the cycle the counter would reach TIMEOUT_CYCLES-1; a valid beat wins
    assign tmo_hit_c   = !read_data_valid && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 2));
    assign last_done_c = beat_v && beat_q.last;
    assign mism_c      = beat_v && (beat_q.data != beat_q.expd);
    assign clean_c     = (err_count == '0) && !mism_c && !tmo_fire_c && !timeout && !overrun;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        tmo_fire_c = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (accept_c) begin
                    state_next = ST_CHECK;
                end else if (tmo_hit_c) begin
                    state_next = ST_DONE;
                    tmo_fire_c = 1'b1;
                end
            end
            ST_CHECK: begin
                if (last_done_c) begin
                    state_next = ST_DONE;
                end else if (tmo_hit_c) begin
                    state_next = ST_DONE;
                    tmo_fire_c = 1'b1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Beat capture, compare bookkeeping and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            overrun        <= 1'b0;
            err_count      <= '0;
            first_err_beat <= '0;
            first_err_data <= '0;
            first_err_exp  <= '0;
            base_q         <= '0;
            total_q        <= '0;
            beat_idx       <= '0;
            tmo_cnt        <= '0;
            ovr_pend       <= 1'b0;
            beat_v         <= 1'b0;
            beat_q         <= '0;
        end else begin
            busy   <= (state_next == ST_ARMED) || (state_next == ST_CHECK);
            done   <= (state_next == ST_DONE);
            beat_v <= accept_c;

            if (accept_c) begin
                beat_q   <= '{data: read_data,
                              expd: exp_c,
                              idx:  beat_idx,
                              last: (beat_idx == total_q - BEAT_W'(1))};
                beat_idx <= beat_idx + BEAT_W'(1);
            end

            if (active_c) begin
                tmo_cnt <= read_data_valid ? '0 : tmo_cnt + TMO_W'(1);
            end

            if ((state == ST_IDLE) && start) begin
                base_q         <= base_addr;
                total_q        <= total_beats(burst_cnt, BEATS_PER_BURST);
                err_count      <= '0;
                first_err_beat <= '0;
                first_err_data <= '0;
                first_err_exp  <= '0;
                timeout        <= 1'b0;
                pass           <= 1'b0;
                // An overrun seen while idle is reported by this check
                overrun        <= ovr_pend || read_data_valid;
                ovr_pend       <= 1'b0;
                beat_idx       <= '0;
                tmo_cnt        <= '0;
            end else begin
                if (read_data_valid && ((state == ST_IDLE) || (state == ST_DONE))) begin
                    overrun  <= 1'b1;
                    ovr_pend <= 1'b1;
                end
                if (mism_c) begin
                    if (err_count == '0) begin
                        first_err_beat <= beat_q.idx;
                        first_err_data <= beat_q.data;
                        first_err_exp  <= beat_q.expd;
                    end
                    if (err_count != ERR_MAX) begin
                        err_count <= err_count + ERR_W'(1);
                    end
                end
                if (tmo_fire_c) begin
                    timeout <= 1'b1;
                end
                if ((state != ST_DONE) && (state_next == ST_DONE)) begin
                    pass <= clean_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_ddr3_read_checker.sv
// Directed self-checking bench for ddr3_read_checker.
module tb_ddr3_read_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [25:0] base_addr;
    logic [4:0]  burst_cnt;
    logic [63:0] read_data;
    logic        read_data_valid;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timeout;
    logic        overrun;
    logic [15:0] err_count;
    logic [9:0]  first_err_beat;
    logic [63:0] first_err_data;
    logic [63:0] first_err_exp;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ddr3_read_checker dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .base_addr       (base_addr),
        .burst_cnt       (burst_cnt),
        .read_data       (read_data),
        .read_data_valid (read_data_valid),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .timeout         (timeout),
        .overrun         (overrun),
        .err_count       (err_count),
        .first_err_beat  (first_err_beat),
        .first_err_data  (first_err_data),
        .first_err_exp   (first_err_exp)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp_v);
        checks++;
        if (got !== exp_v) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp_v);
        end
    endtask

    function automatic logic [63:0] pat(input logic [25:0] b, input int idx);
        logic [31:0] w;
        w = {6'b0, b} + 32'(idx);
        return {~w, w};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [25:0] b, input logic [4:0] bc);
        base_addr = b;
        burst_cnt = bc;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] d, input int gap);
        read_data       = d;
        read_data_valid = 1'b1;
        tick();
        read_data_valid = 1'b0;
        repeat (gap) tick();
    endtask

    // Cycles from the last valid beat's cycle to the first cycle with done high
    task automatic wait_done(input int lim, output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < lim) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        int seen;
        logic [63:0] d;

        rst = 1'b1; start = 1'b0; base_addr = '0; burst_cnt = '0;
        read_data = '0; read_data_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        check_val("rst_busy",    64'(busy),           64'd0);
        check_val("rst_done",    64'(done),           64'd0);
        check_val("rst_pass",    64'(pass),           64'd0);
        check_val("rst_timeout", 64'(timeout),        64'd0);
        check_val("rst_overrun", 64'(overrun),        64'd0);
        check_val("rst_err",     64'(err_count),      64'd0);
        check_val("rst_fbeat",   64'(first_err_beat), 64'd0);
        check_val("rst_fdata",   first_err_data,      64'd0);

        // Clean 2-burst check, back to back
        do_start(26'h100, 5'd2);
        check_val("t1_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 4; i++) send_beat(pat(26'h100, i), 0);
        wait_done(50, cyc);
        check_val("t1_latency",  64'(cyc),       64'd2);
        check_val("t1_pass",     64'(pass),      64'd1);
        check_val("t1_err",      64'(err_count), 64'd0);
        check_val("t1_busy_off", 64'(busy),      64'd0);
        tick();
        check_val("t1_done_pulse", 64'(done), 64'd0);
        check_val("t1_pass_hold",  64'(pass), 64'd1);

        // Beat 2 corrupted in bit 0
        do_start(26'h100, 5'd2);
        for (int i = 0; i < 4; i++) begin
            d = pat(26'h100, i);
            if (i == 2) d = d ^ 64'd1;
            send_beat(d, 0);
        end
        wait_done(50, cyc);
        check_val("t2_latency", 64'(cyc),            64'd2);
        check_val("t2_pass",    64'(pass),           64'd0);
        check_val("t2_err",     64'(err_count),      64'd1);
        check_val("t2_fbeat",   64'(first_err_beat), 64'd2);
        check_val("t2_fexp",    first_err_exp,       64'hFFFFFEFD_00000102);
        check_val("t2_fdata",   first_err_data,      64'hFFFFFEFD_00000103);
        tick();

        // 32 bursts, gapped beats, every beat wrong
        do_start(26'h3FFFFC0, 5'd0);
        for (int i = 0; i < 64; i++) send_beat(~pat(26'h3FFFFC0, i), (i == 63) ? 0 : (i % 6));
        wait_done(50, cyc);
        check_val("t3_latency", 64'(cyc),            64'd2);
        check_val("t3_err",     64'(err_count),      64'd64);
        check_val("t3_fbeat",   64'(first_err_beat), 64'd0);
        check_val("t3_fdata",   first_err_data,      64'h03FFFFC0_FC00003F);
        check_val("t3_fexp",    first_err_exp,       64'hFC00003F_03FFFFC0);
        check_val("t3_pass",    64'(pass),           64'd0);
        check_val("t3_timeout", 64'(timeout),        64'd0);
        tick();

        // Only 3 of 4 beats arrive
        do_start(26'h40, 5'd2);
        for (int i = 0; i < 3; i++) send_beat(pat(26'h40, i), 0);
        wait_done(3000, cyc);
        check_val("t4_latency", 64'(cyc),       64'd1024);
        check_val("t4_timeout", 64'(timeout),   64'd1);
        check_val("t4_pass",    64'(pass),      64'd0);
        check_val("t4_err",     64'(err_count), 64'd0);
        tick();

        // Valid beat while idle, then two clean checks
        tick();
        send_beat(64'h0, 0);
        check_val("t5_ovr_idle", 64'(overrun), 64'd1);
        do_start(26'h200, 5'd2);
        check_val("t5_ovr_start", 64'(overrun), 64'd1);
        for (int i = 0; i < 4; i++) send_beat(pat(26'h200, i), 0);
        wait_done(50, cyc);
        check_val("t5_pass_ovr", 64'(pass),      64'd0);
        check_val("t5_ovr_done", 64'(overrun),   64'd1);
        check_val("t5_err",      64'(err_count), 64'd0);
        tick();
        do_start(26'h200, 5'd2);
        check_val("t5_ovr_clear", 64'(overrun), 64'd0);
        for (int i = 0; i < 4; i++) send_beat(pat(26'h200, i), 0);
        wait_done(50, cyc);
        check_val("t5_pass_clean", 64'(pass), 64'd1);
        tick();

        // Reset mid-check, then re-arm and ignore a second start
        do_start(26'h100, 5'd2);
        send_beat(pat(26'h100, 0) ^ 64'd1, 0);
        send_beat(pat(26'h100, 1), 0);
        tick();
        check_val("t6_err_pre", 64'(err_count), 64'd1);
        #2 rst = 1'b1;
        #1;
        check_val("t6_rst_busy",  64'(busy),      64'd0);
        check_val("t6_rst_err",   64'(err_count), 64'd0);
        check_val("t6_rst_fdata", first_err_data, 64'd0);
        check_val("t6_rst_done",  64'(done),      64'd0);
        tick();
        rst  = 1'b0;
        seen = 0;
        repeat (5) begin
            tick();
            if (done === 1'b1) seen++;
        end
        check_val("t6_no_done", 64'(seen), 64'd0);
        do_start(26'h100, 5'd2);
        send_beat(pat(26'h100, 0), 0);
        do_start(26'h155, 5'd1);
        for (int i = 1; i < 4; i++) send_beat(pat(26'h100, i), 0);
        wait_done(50, cyc);
        check_val("t6_latency", 64'(cyc),       64'd2);
        check_val("t6_pass",    64'(pass),      64'd1);
        check_val("t6_err",     64'(err_count), 64'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
